// File: rtl/mc_wb_arb_pkg.sv
// mc_wb_arb_pkg: shared FSM encoding, watchdog default and index-width helper for the WISHBONE arbiter
package mc_wb_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;
  localparam int ARB_TO_DEF = 256;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mc_wb_arb_rr_pick.sv
// mc_wb_arb_rr_pick: combinational round-robin picker; req_i requests, last_i previous winner, onehot_o winner, valid_o any request
module mc_wb_arb_rr_pick
  import mc_wb_arb_pkg::*;
#(
  parameter int NM = 4,
  localparam int IW = idx_w(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NM-1:0] onehot_o,
  output logic          valid_o
);
  logic [IW-1:0] k;
  always_comb begin
    onehot_o = '0;
    k = '0;
    for (int i = 1; i <= NM; i++) begin
      k = IW'((int'(last_i) + i) % NM);
      if (req_i[k] && onehot_o == '0) onehot_o[k] = 1'b1;
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/mc_wb_arb.sv
// mc_wb_arb: round-robin WISHBONE arbiter with burst-atomic grants and watchdog abort; m_* master side, s_* controller side, gnt_o/busy_o status
module mc_wb_arb
  import mc_wb_arb_pkg::*;
#(
  parameter int NM     = 4,
  parameter int TO_CYC = ARB_TO_DEF,
  parameter int TO_W   = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [4*NM-1:0]   m_sel_i,
  input  logic [32*NM-1:0]  m_addr_i,
  input  logic [32*NM-1:0]  m_data_i,
  output logic [31:0]       m_data_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [31:0]       s_addr_o,
  output logic [31:0]       s_data_o,
  input  logic [31:0]       s_data_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [NM-1:0]     gnt_o,
  output logic              busy_o
);
  localparam int IW = idx_w(NM);
  localparam logic [TO_W-1:0] LIM = TO_W'(TO_CYC > 0 ? TO_CYC - 1 : 0);
  arb_state_e      state_q;
  logic [NM-1:0]   gnt_q;
  logic [IW-1:0]   last_q;
  logic [TO_W-1:0] wdog_q;
  logic [NM-1:0]   pick_oh;
  logic            pick_v;
  logic [IW-1:0]   pick_idx;
  logic            act, own_cyc, own_stb, cnt_en, to_hit;
  logic [3:0]      sel_mux;
  logic [31:0]     addr_mux, data_mux;
  mc_wb_arb_rr_pick #(.NM(NM)) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .onehot_o(pick_oh),
    .valid_o (pick_v)
  );
  assign act     = state_q == ARB_GRANT;
  assign own_cyc = |(gnt_q & m_cyc_i);
  assign own_stb = |(gnt_q & m_stb_i);
  // The watchdog only runs while the owner strobes and the slave stays silent.
  assign cnt_en  = (TO_CYC != 0) && act && own_cyc && own_stb && !s_ack_i && !s_err_i;
  assign to_hit  = cnt_en && wdog_q == LIM;
  // gnt_q is one-hot or zero, so an AND-OR mux yields all-zero payload when idle.
  always_comb begin
    pick_idx = '0;
    sel_mux  = '0;
    addr_mux = '0;
    data_mux = '0;
    for (int i = 0; i < NM; i++) begin
      if (pick_oh[i]) pick_idx = IW'(i);
      sel_mux  |= m_sel_i[4*i +: 4] & {4{gnt_q[i]}};
      addr_mux |= m_addr_i[32*i +: 32] & {32{gnt_q[i]}};
      data_mux |= m_data_i[32*i +: 32] & {32{gnt_q[i]}};
    end
  end
  assign s_cyc_o  = act & own_cyc;
  assign s_stb_o  = act & own_stb;
  assign s_we_o   = |(gnt_q & m_we_i);
  assign s_sel_o  = sel_mux;
  assign s_addr_o = addr_mux;
  assign s_data_o = data_mux;
  assign m_data_o = s_data_i;
  assign m_ack_o  = act ? gnt_q & {NM{s_ack_i}} : '0;
  assign m_err_o  = act ? gnt_q & {NM{s_err_i | to_hit}} : '0;
  assign gnt_o    = gnt_q;
  assign busy_o   = state_q != ARB_IDLE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NM - 1);
      wdog_q  <= '0;
    end else begin
      wdog_q <= cnt_en ? (wdog_q == LIM ? wdog_q : wdog_q + 1'b1) : '0;
      case (state_q)
        ARB_IDLE: if (pick_v) begin
          state_q <= ARB_GRANT;
          gnt_q   <= pick_oh;
          last_q  <= pick_idx;
        end
        // Release outranks the watchdog; ABORT holds the grant until the owner lets go.
        ARB_GRANT: if (!own_cyc) begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
        end else if (to_hit) state_q <= ARB_ABORT;
        ARB_ABORT: if (!own_cyc) begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mc_wb_arb.sv
// tb_mc_wb_arb: self-checking bench for mc_wb_arb (NM=4, TO_CYC=4)
module tb_mc_wb_arb;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   m_cyc, m_stb, m_we;
  logic [15:0]  m_sel;
  logic [127:0] m_addr, m_wdata;
  logic [31:0]  m_rdata;
  logic [3:0]   m_ack, m_err;
  logic         s_cyc, s_stb, s_we;
  logic [3:0]   s_sel;
  logic [31:0]  s_addr, s_wdata, s_rdata;
  logic         s_ack, s_err;
  logic [3:0]   gnt;
  logic         busy;
  int           checks = 0;
  int           errors = 0;
  typedef struct {logic [3:0] req; int exp;} vec_t;
  typedef struct {int m; logic [31:0] d;} sb_t;
  vec_t tbl[11];
  sb_t  sb[$];
  always #5 clk = ~clk;
  mc_wb_arb #(.NM(4), .TO_CYC(4), .TO_W(9)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_addr_i(m_addr), .m_data_i(m_wdata), .m_data_o(m_rdata),
    .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_addr_o(s_addr), .s_data_o(s_wdata), .s_data_i(s_rdata),
    .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt), .busy_o(busy)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push(input int m, input logic [31:0] d);
    sb_t e;
    e.m = m;
    e.d = d;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    #2;
    if (m_ack != 4'b0) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 1);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_ack_dest", m_ack, 4'b1 << e.m);
        chk("sb_rdata", m_rdata, e.d);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] we_pat;
    int ord[5];
    tbl[0]  = '{4'b0001, 0};
    tbl[1]  = '{4'b0011, 1};
    tbl[2]  = '{4'b0011, 0};
    tbl[3]  = '{4'b1100, 2};
    tbl[4]  = '{4'b1100, 3};
    tbl[5]  = '{4'b1010, 1};
    tbl[6]  = '{4'b1010, 3};
    tbl[7]  = '{4'b0100, 2};
    tbl[8]  = '{4'b1111, 3};
    tbl[9]  = '{4'b1111, 0};
    tbl[10] = '{4'b1000, 3};
    ord = '{0, 1, 2, 3, 0};
    we_pat = 4'b1010;
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
    m_addr = '0; m_wdata = '0; s_rdata = '0; s_ack = 1'b0; s_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ctl", {s_cyc, s_stb, s_we, s_sel}, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_ack_err", {m_ack, m_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // single read by m0, slave acks on cycle 3
    @(negedge clk);
    m_cyc = 4'b0001; m_stb = 4'b0001; m_sel[3:0] = 4'hF; m_addr[31:0] = 32'h40;
    #1 chk("t1_no_gnt_yet", gnt, 0);
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_s_addr", s_addr, 32'h40);
    chk("t1_s_cyc", {s_cyc, s_stb}, 2'b11);
    chk("t1_no_ack", m_ack, 0);
    tick();
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF; push(0, 32'hDEADBEEF);
    #1 chk("t1_ack", m_ack, 4'b0001);
    chk("t1_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick();
    chk("t1_idle", {busy, gnt}, 0);
    // arbitration table
    m_addr  = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    m_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    m_sel   = {4'h8, 4'h4, 4'h2, 4'h1};
    m_we    = we_pat;
    for (int i = 0; i < 11; i++) begin
      m_cyc = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d_gnt", i), gnt, 4'b1 << tbl[i].exp);
      chk($sformatf("tbl%0d_addr", i), s_addr, 32'h1000 * (tbl[i].exp + 1));
      chk($sformatf("tbl%0d_wdata", i), s_wdata, 32'hD0 + tbl[i].exp);
      chk($sformatf("tbl%0d_sel", i), s_sel, 4'b1 << tbl[i].exp);
      chk($sformatf("tbl%0d_we", i), s_we, we_pat[tbl[i].exp]);
      chk($sformatf("tbl%0d_cyc", i), {busy, s_cyc}, 2'b11);
      m_cyc = '0;
      tick();
      chk($sformatf("tbl%0d_release", i), gnt, 0);
    end
    // all four request; each drops cyc with its ack
    m_cyc = 4'b1111; m_stb = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("t2_gnt%0d", j), gnt, 4'b1 << ord[j]);
      s_ack = 1'b1; s_rdata = 32'hA0 + 32'(j); push(ord[j], 32'hA0 + 32'(j));
      m_cyc[ord[j]] = 1'b0; m_stb[ord[j]] = 1'b0;
      #1 chk($sformatf("t2_ack%0d", j), m_ack, 4'b1 << ord[j]);
      tick();
      s_ack = 1'b0;
      chk($sformatf("t2_gap%0d", j), gnt, 0);
      if (j == 0) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      end
    end
    // m1 8-beat burst while m2 waits
    m_cyc = 4'b0110; m_stb = 4'b0110;
    tick();
    chk("t3_gnt_m1", gnt, 4'b0010);
    for (int b = 0; b < 8; b++) begin
      s_ack = 1'b1; s_rdata = 32'h100 + 32'(b); push(1, 32'h100 + 32'(b));
      #1 chk($sformatf("t3_ack%0d", b), m_ack, 4'b0010);
      chk($sformatf("t3_hold%0d", b), gnt, 4'b0010);
      tick();
    end
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1 chk("t3_still_m1", gnt, 4'b0010);
    tick();
    chk("t3_gap", gnt, 0);
    tick();
    chk("t3_gnt_m2", gnt, 4'b0100);
    // m2 strobes, slave never answers: watchdog fires on the 4th stb cycle
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t4_err_c%0d", c), m_err, c == 4 ? 4'b0100 : 4'b0000);
      chk($sformatf("t4_ack_c%0d", c), m_ack, 0);
      if (c < 4) tick();
    end
    tick();
    chk("t4_abort_cyc", {s_cyc, s_stb}, 0);
    chk("t4_abort_busy", busy, 1);
    chk("t4_abort_gnt", gnt, 4'b0100);
    chk("t4_abort_err", m_err, 0);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();
    chk("t4_idle", {busy, gnt}, 0);
    // m3: ack exactly at the watchdog limit wins
    m_cyc = 4'b1000; m_stb = 4'b1000;
    tick();
    chk("t5_gnt_m3", gnt, 4'b1000);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("t5_noerr_c%0d", c), m_err, 0);
      tick();
    end
    s_ack = 1'b1; s_rdata = 32'h55AA; push(3, 32'h55AA);
    #1 chk("t5_ack_limit", m_ack, 4'b1000);
    chk("t5_err_limit", m_err, 0);
    tick();
    s_ack = 1'b0;
    #1 chk("t5_no_abort", {busy, s_cyc}, 2'b11);
    @(negedge clk);
    s_ack = 1'b1; s_rdata = 32'h77; push(3, 32'h77);
    m_cyc = 4'b1001; m_stb = 4'b1001;
    #1 chk("t5_ack_pre_rst", m_ack, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_s", {s_cyc, s_stb, s_we, s_sel}, 0);
    chk("t5_rst_addr", s_addr, 0);
    chk("t5_rst_ack_err", {m_ack, m_err}, 0);
    chk("t5_rst_busy", busy, 0);
    s_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_first_gnt", gnt, 4'b0001);
    m_cyc = '0; m_stb = '0;
    tick();
    tick();
    chk("sb_drain", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
